ps2_cmd_arbiter: RTL

Shares the single PS/2 transmitter and acknowledge path between two command requesters: requester 0 is the mouse master state machine, and requester 1 is the host configuration port (sample rate, resolution, stream enable/disable). It accepts one command byte at a time and drives it to the transmitter. It then checks the mouse acknowledge byte, resends on FE or timeout, and returns a per-requester completion pulse with a response code. It sits between the requesters and the PS/2 transmitter/receiver pair.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_rr_arb2.sv | 17 +
 rtl/ps2_cmd_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 command-path definitions: protocol bytes, arbiter states, response codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ps2_pkg;

   // Mouse reply bytes the arbiter reacts to
   localparam logic [7:0] ACK_FA    = 8'hFA;
   localparam logic [7:0] RESEND_FE = 8'hFE;
   localparam logic [7:0] ERROR_FC  = 8'hFC;

   // Command arbiter states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_SENT,
      ST_WAIT_ACK,
      ST_RESP
   } state_t;

   // Completion codes returned with DONE
   typedef enum logic [1:0] {
      RESP_OK        = 2'b00,
      RESP_MOUSE_ERR = 2'b01,
      RESP_RETRY_EXH = 2'b10,
      RESP_RX_ERR    = 2'b11
   } resp_t;

endpackage

// File: rtl/ps2_rr_arb2.sv
// Two-way round-robin grant: the requester that was not served last wins a tie.
// Latency: combinational.
// Backpressure: a losing requester must hold its valid until granted.
module ps2_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   // Requester 0 wins alone or on a tie after requester 1 was served; symmetric for 1
   always_comb begin
      grant    = 2'b00;
      grant[0] = valid[0] & (~valid[1] | last);
      grant[1] = valid[1] & (~valid[0] | ~last);
   end

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Shares one PS/2 transmitter/ack path between two requesters, with FE/timeout resend.
// Latency: SEND_BYTE one cycle after acceptance; DONE one cycle after the deciding ack byte.
// Backpressure: READY only in IDLE; one command in flight, the other requester holds VALID.
module ps2_cmd_arbiter
   import ps2_pkg::*;
#(
   parameter int ACK_TIMEOUT = 500000,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 24
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0_VALID,
   input  logic [7:0] REQ0_BYTE,
   output logic       REQ0_READY,
   output logic       REQ0_DONE,
   input  logic       REQ1_VALID,
   input  logic [7:0] REQ1_BYTE,
   output logic       REQ1_READY,
   output logic       REQ1_DONE,
   output logic [1:0] RESP_CODE,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   output logic       BUSY
);

   localparam int               RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   // The counter reaches ACK_TIMEOUT on the increment out of this value
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [RTY_W-1:0] rty_q, rty_nxt;
   logic             owner_q, owner_nxt;
   logic             last_q, last_nxt;
   logic [7:0]       byte_nxt;
   logic [1:0]       code_nxt;
   logic [1:0]       grant;
   logic             idle;
   logic             accept;
   logic             retry_evt;

   assign idle = (state_q == ST_IDLE);

   ps2_rr_arb2 u_arb (
      .valid ({REQ1_VALID, REQ0_VALID}),
      .last  (last_q),
      .grant (grant)
   );

   assign REQ0_READY = idle & grant[0] & ~RESET;
   assign REQ1_READY = idle & grant[1] & ~RESET;
   assign accept     = REQ0_READY | REQ1_READY;

   // Next-state, counters and latched command/response fields
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      rty_nxt   = rty_q;
      owner_nxt = owner_q;
      last_nxt  = last_q;
      byte_nxt  = BYTE_TO_SEND;
      code_nxt  = RESP_CODE;
      retry_evt = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SEND;
               byte_nxt  = grant[1] ? REQ1_BYTE : REQ0_BYTE;
               owner_nxt = grant[1];
               last_nxt  = grant[1];
               rty_nxt   = '0;
               cnt_nxt   = '0;
            end
         end

         // Transmitter completion is not looked at until WAIT_SENT
         ST_SEND: state_nxt = ST_WAIT_SENT;

         ST_WAIT_SENT: begin
            if (BYTE_SENT) begin
               state_nxt = ST_WAIT_ACK;
               cnt_nxt   = '0;
            end else if (cnt_q == CNT_LAST) begin
               retry_evt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         // Receive error beats any byte; any byte beats the timeout
         ST_WAIT_ACK: begin
            if (BYTE_ERROR_CODE != 2'b00) begin
               state_nxt = ST_RESP;
               code_nxt  = RESP_RX_ERR;
            end else if (BYTE_READY) begin
               if (BYTE_READ == ACK_FA) begin
                  state_nxt = ST_RESP;
                  code_nxt  = RESP_OK;
               end else if (BYTE_READ == RESEND_FE) begin
                  retry_evt = 1'b1;
               end else begin
                  state_nxt = ST_RESP;
                  code_nxt  = RESP_MOUSE_ERR;
               end
            end else if (cnt_q == CNT_LAST) begin
               retry_evt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: state_nxt = ST_IDLE;

         default: state_nxt = ST_IDLE;
      endcase

      // Resend the same byte while attempts remain, otherwise give up
      if (retry_evt) begin
         if (rty_q < RTY_MAX) begin
            rty_nxt   = rty_q + RTY_W'(1);
            cnt_nxt   = '0;
            state_nxt = ST_SEND;
         end else begin
            state_nxt = ST_RESP;
            code_nxt  = RESP_RETRY_EXH;
         end
      end
   end

   // State, datapath and registered outputs (outputs decoded from next state)
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rty_q        <= '0;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         BYTE_TO_SEND <= 8'h00;
         RESP_CODE    <= RESP_OK;
         SEND_BYTE    <= 1'b0;
         READ_ENABLE  <= 1'b0;
         BUSY         <= 1'b0;
         REQ0_DONE    <= 1'b0;
         REQ1_DONE    <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         cnt_q        <= cnt_nxt;
         rty_q        <= rty_nxt;
         owner_q      <= owner_nxt;
         last_q       <= last_nxt;
         BYTE_TO_SEND <= byte_nxt;
         RESP_CODE    <= code_nxt;
         SEND_BYTE    <= (state_nxt == ST_SEND);
         READ_ENABLE  <= (state_nxt == ST_WAIT_ACK);
         BUSY         <= (state_nxt != ST_IDLE);
         REQ0_DONE    <= (state_nxt == ST_RESP) & ~owner_nxt;
         REQ1_DONE    <= (state_nxt == ST_RESP) & owner_nxt;
      end
   end

endmodule
